// File: rtl/risc_pipe_core_if.sv
// Instruction/retire/debug bundle for risc_pipe_core.
// master = instruction source and result consumer; slave = the core.
interface risc_pipe_core_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  stall;
   logic                  instr_valid;
   logic [31:0]           instr_in;
   logic                  instr_ready;
   logic                  result_valid;
   logic [REG_ADDR_W-1:0] result_addr;
   logic [DATA_W-1:0]     result_data;
   logic                  illegal;
   logic [REG_ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0]     dbg_data;

   modport master (
      output stall, instr_valid, instr_in, dbg_addr,
      input  instr_ready, result_valid, result_addr, result_data, illegal, dbg_data
   );

   modport slave (
      input  stall, instr_valid, instr_in, dbg_addr,
      output instr_ready, result_valid, result_addr, result_data, illegal, dbg_data
   );
endinterface

// File: rtl/risc_pipe_core.sv
// 3-stage DLX-style integer pipeline: S1 decode latch, S2 operand read, S3 execute/writeback.
// Optional feature macro RISC_FWD_EN: bypass the S3 result into S2 instead of inserting a bubble.
module risc_pipe_core #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic            clock,
   input  logic            reset_n,
   risc_pipe_core_if.slave bus
);
   localparam int NUM_REGS = 2 ** REG_ADDR_W;

   localparam logic [5:0] OP_ADD = 6'd1;
   localparam logic [5:0] OP_SUB = 6'd2;
   localparam logic [5:0] OP_OR  = 6'd3;
   localparam logic [5:0] OP_AND = 6'd4;
   localparam logic [5:0] OP_XOR = 6'd5;
   localparam logic [5:0] OP_SLT = 6'd6;
   localparam logic [5:0] OP_LDI = 6'd7;

   // S1 decode latch
   logic                  s1_valid_reg;
   logic [5:0]            s1_op_reg;
   logic [REG_ADDR_W-1:0] s1_rd_reg;
   logic [REG_ADDR_W-1:0] s1_rs1_reg;
   logic [REG_ADDR_W-1:0] s1_rs2_reg;
   logic [15:0]           s1_imm_reg;

   // S2 operand latch
   logic                  s2_valid_reg;
   logic [5:0]            s2_op_reg;
   logic [REG_ADDR_W-1:0] s2_rd_reg;
   logic [DATA_W-1:0]     s2_a_reg;
   logic [DATA_W-1:0]     s2_b_reg;
   logic [15:0]           s2_imm_reg;

   logic                  result_valid_reg;
   logic                  illegal_reg;
   logic [REG_ADDR_W-1:0] result_addr_reg;
   logic [DATA_W-1:0]     result_data_reg;

   wire  [DATA_W-1:0]     gpr [NUM_REGS];

   logic [DATA_W-1:0]     alu_result;
   logic                  s2_writes;
   logic                  wr_en;
   logic                  s2_illegal;
   logic                  hazard;
   logic [DATA_W-1:0]     op_a;
   logic [DATA_W-1:0]     op_b;
   logic                  unused_fields;

   assign unused_fields = ^bus.instr_in[25:21];

   // S3: execute on the S2 operands
   always_comb begin
      alu_result = '0;
      case (s2_op_reg)
         OP_ADD:  alu_result = s2_a_reg + s2_b_reg;
         OP_SUB:  alu_result = s2_a_reg - s2_b_reg;
         OP_OR:   alu_result = s2_a_reg | s2_b_reg;
         OP_AND:  alu_result = s2_a_reg & s2_b_reg;
         OP_XOR:  alu_result = s2_a_reg ^ s2_b_reg;
         OP_SLT:  alu_result = DATA_W'($signed(s2_a_reg) < $signed(s2_b_reg));
         OP_LDI:  alu_result = DATA_W'(s2_imm_reg);
         default: alu_result = '0;
      endcase
   end

   assign s2_writes  = s2_valid_reg && (s2_op_reg >= OP_ADD) && (s2_op_reg <= OP_LDI)
                       && (s2_rd_reg != '0);
   assign wr_en      = s2_writes && !bus.stall;
   assign s2_illegal = s2_valid_reg && (s2_op_reg > OP_LDI);

`ifdef RISC_FWD_EN
   assign hazard = 1'b0;
`else
   assign hazard = s1_valid_reg && s2_writes
                   && ((s1_rs1_reg == s2_rd_reg) || (s1_rs2_reg == s2_rd_reg));
`endif

   // Write-through on a same-edge write; with RISC_FWD_EN this is also the bypass path.
   always_comb begin
      op_a = gpr[s1_rs1_reg];
      op_b = gpr[s1_rs2_reg];
      if (wr_en && (s1_rs1_reg == s2_rd_reg)) op_a = alu_result;
      if (wr_en && (s1_rs2_reg == s2_rd_reg)) op_b = alu_result;
   end

   assign bus.instr_ready = !bus.stall && !hazard;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_reg <= 1'b0;
         s1_op_reg    <= '0;
         s1_rd_reg    <= '0;
         s1_rs1_reg   <= '0;
         s1_rs2_reg   <= '0;
         s1_imm_reg   <= '0;
      end else if (!bus.stall && !hazard) begin
         s1_valid_reg <= bus.instr_valid;
         s1_op_reg    <= bus.instr_in[31:26];
         s1_rd_reg    <= bus.instr_in[16 +: REG_ADDR_W];
         s1_rs2_reg   <= bus.instr_in[11 +: REG_ADDR_W];
         s1_rs1_reg   <= bus.instr_in[6 +: REG_ADDR_W];
         s1_imm_reg   <= bus.instr_in[15:0];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid_reg <= 1'b0;
         s2_op_reg    <= '0;
         s2_rd_reg    <= '0;
         s2_a_reg     <= '0;
         s2_b_reg     <= '0;
         s2_imm_reg   <= '0;
      end else if (!bus.stall) begin
         s2_valid_reg <= s1_valid_reg && !hazard;
         s2_op_reg    <= s1_op_reg;
         s2_rd_reg    <= s1_rd_reg;
         s2_a_reg     <= op_a;
         s2_b_reg     <= op_b;
         s2_imm_reg   <= s1_imm_reg;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result_valid_reg <= 1'b0;
         illegal_reg      <= 1'b0;
         result_addr_reg  <= '0;
         result_data_reg  <= '0;
      end else begin
         result_valid_reg <= wr_en;
         illegal_reg      <= s2_illegal && !bus.stall;
         if (wr_en) begin
            result_addr_reg <= s2_rd_reg;
            result_data_reg <= alu_result;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_gpr
         if (gi == 0) begin : g_zero
            assign gpr[gi] = '0;
         end else begin : g_reg
            logic [DATA_W-1:0] q_reg;
            always_ff @(posedge clock or negedge reset_n) begin
               if (!reset_n)
                  q_reg <= DATA_W'(gi);
               else if (wr_en && (s2_rd_reg == REG_ADDR_W'(gi)))
                  q_reg <= alu_result;
            end
            assign gpr[gi] = q_reg;
         end
      end
   endgenerate

   assign bus.result_valid = result_valid_reg;
   assign bus.illegal      = illegal_reg;
   assign bus.result_addr  = result_addr_reg;
   assign bus.result_data  = result_data_reg;
   assign bus.dbg_data     = gpr[bus.dbg_addr];
endmodule

// File: tb/tb_risc_pipe_core.sv
// Bench for risc_pipe_core: directed vector tables, multi-cycle corner sequences,
// and a random instruction stream checked against a sequential program-order model.
module tb_risc_pipe_core;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 32;
`ifdef RISC_FWD_EN
   localparam int XTRA = 0;
`else
   localparam int XTRA = 1;
`endif

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;

   risc_pipe_core_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();
   risc_pipe_core #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; int c;} obs_t;
   typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
   typedef struct {logic [31:0] instr; bit pulse; logic [AW-1:0] a; logic [DW-1:0] d; bit ill;} vec_t;

   obs_t          obs [$];
   exp_t          exp_q [$];
   vec_t          tbl [9];
   int            acc_edge [9];
   logic [DW-1:0] mgpr [NREG];
   int            checks  = 0;
   int            errors  = 0;
   int            cyc     = 0;
   int            ill_cnt = 0;
   bit            stall_q = 1'b0;
   bit            rand_done;

   always @(posedge clock) begin
      cyc     = cyc + 1;
      stall_q = bus.stall;
   end

   // Retirement monitor, plus the rule that a stalled edge retires nothing.
   always @(negedge clock) begin
      if (bus.result_valid === 1'b1) obs.push_back('{bus.result_addr, bus.result_data, cyc});
      if (bus.illegal === 1'b1) ill_cnt = ill_cnt + 1;
      if (stall_q && reset_n) begin
         checks = checks + 1;
         if (bus.result_valid !== 1'b0 || bus.illegal !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL stall_quiet: cycle %0d result_valid=%b illegal=%b, required 0/0",
                     cyc, bus.result_valid, bus.illegal);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h, required %0h", nm, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NREG; i++) mgpr[i] = DW'(i);
   endfunction

   // Program-order semantics: each instruction sees all earlier results.
   function automatic void model_exec(input logic [31:0] ins, output bit wr, output bit ill,
                                      output logic [AW-1:0] a, output logic [DW-1:0] d);
      logic [5:0]    op;
      logic [DW-1:0] x, y;
      op = ins[31:26];
      a  = ins[20:16];
      x  = mgpr[ins[10:6]];
      y  = mgpr[ins[15:11]];
      case (op)
         6'd1:    d = x + y;
         6'd2:    d = x - y;
         6'd3:    d = x | y;
         6'd4:    d = x & y;
         6'd5:    d = x ^ y;
         6'd6:    d = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         6'd7:    d = {16'h0000, ins[15:0]};
         default: d = '0;
      endcase
      wr  = (op >= 6'd1) && (op <= 6'd7) && (a != 0);
      ill = (op > 6'd7);
      if (wr) mgpr[a] = d;
   endfunction

   // Called just after a rising edge; returns the edge index at which the instruction was accepted.
   task automatic send(input logic [31:0] ins, output int eidx);
      bit acc;
      bus.instr_valid = 1'b1;
      bus.instr_in    = ins;
      eidx            = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         acc = bus.instr_ready;
         @(posedge clock);
         #1;
         if (acc) begin
            eidx = cyc;
            break;
         end
      end
      if (eidx < 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL send_timeout: instr %h not accepted within 50 cycles, required accept", ins);
      end
   endtask

   task automatic idle(input int n);
      bus.instr_valid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NREG; i++) begin
         bus.dbg_addr = AW'(i);
         #1;
         chk($sformatf("%s_r%0d", tag, i), bus.dbg_data, mgpr[i]);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic release_reset();
      #3 reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic run_table(input int lo, input int hi, input bit timing, input string tag);
      int  j;
      int  n_ill;
      bit  wr, il;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      obs.delete();
      ill_cnt = 0;
      for (int i = lo; i <= hi; i++) begin
         send(tbl[i].instr, acc_edge[i]);
         model_exec(tbl[i].instr, wr, il, a, d);
      end
      idle(8);
      j     = 0;
      n_ill = 0;
      for (int i = lo; i <= hi; i++) begin
         if (tbl[i].ill) n_ill++;
         if (tbl[i].pulse) begin
            if (j < obs.size()) begin
               chk($sformatf("%s_addr%0d", tag, i), obs[j].a, tbl[i].a);
               chk($sformatf("%s_data%0d", tag, i), obs[j].d, tbl[i].d);
               if (timing) chk($sformatf("%s_edge%0d", tag, i), obs[j].c, acc_edge[i] + 2);
            end
            j++;
         end
      end
      chk({tag, "_pulses"}, obs.size(), j);
      chk({tag, "_illegal"}, ill_cnt, n_ill);
   endtask

   initial begin
      int e0, e1, e2;
      int exp_ill;
      bus.stall       = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr_in    = '0;
      bus.dbg_addr    = '0;
      model_reset();

      tbl[0] = '{32'h04031040, 1'b1, 5'd3,  32'd3,        1'b0};
      tbl[1] = '{32'h0C062900, 1'b1, 5'd6,  32'd5,        1'b0};
      tbl[2] = '{32'h10094380, 1'b1, 5'd9,  32'd8,        1'b0};
      tbl[3] = '{32'h140C5A80, 1'b1, 5'd12, 32'd1,        1'b0};
      tbl[4] = '{32'h00000000, 1'b0, 5'd0,  32'd0,        1'b0};
      tbl[5] = '{32'h1C07BEEF, 1'b1, 5'd7,  32'h0000BEEF, 1'b0};
      tbl[6] = '{32'h08081040, 1'b1, 5'd8,  32'hFFFFFFFF, 1'b0};
      tbl[7] = '{32'h18090A00, 1'b1, 5'd9,  32'd1,        1'b0};
      tbl[8] = '{32'hFC000000, 1'b0, 5'd0,  32'd0,        1'b1};

      // Power-up reset
      #1 reset_n = 1'b0;
      #2;
      chk("rst_result_valid", bus.result_valid, 0);
      chk("rst_illegal", bus.illegal, 0);
      chk("rst_result_addr", bus.result_addr, 0);
      chk("rst_result_data", bus.result_data, 0);
      check_regs("rst");
      release_reset();
      chk("rst_instr_ready", bus.instr_ready, 1);

      run_table(0, 4, 1'b1, "alu");
      run_table(5, 8, 1'b0, "ldi_sub_slt");
      check_regs("after_tables");

      // RAW: r4 = r3 + r3 right behind r3's producer, followed by a NOOP
      obs.delete();
      send(32'h04031040, e0);
      send(32'h040418C0, e1);
      send(32'h00000000, e2);
      idle(8);
      chk("raw_accept2", e1, e0 + 1);
      chk("raw_accept3", e2, e0 + 2 + XTRA);
      chk("raw_pulses", obs.size(), 2);
      if (obs.size() == 2) begin
         chk("raw_r3_edge", obs[0].c, e0 + 2);
         chk("raw_r4_addr", obs[1].a, 4);
         chk("raw_r4_data", obs[1].d, 6);
         chk("raw_r4_edge", obs[1].c, e0 + 3 + XTRA);
      end
      mgpr[4] = 32'd6;

      // Stall for three edges after accept
      obs.delete();
      send(32'h04031040, e0);
      bus.instr_valid = 1'b0;
      bus.stall       = 1'b1;
      repeat (3) @(posedge clock);
      #1 bus.stall = 1'b0;
      idle(6);
      chk("stall_pulses", obs.size(), 1);
      if (obs.size() == 1) begin
         chk("stall_addr", obs[0].a, 3);
         chk("stall_data", obs[0].d, 3);
         chk("stall_edge", obs[0].c, e0 + 5);
      end

      // Mid-cycle reset while a result pulse is showing
      obs.delete();
      send(32'h04031040, e0);
      bus.instr_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #3;
      chk("midrst_pre_valid", bus.result_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_result_valid", bus.result_valid, 0);
      chk("midrst_illegal", bus.illegal, 0);
      chk("midrst_result_addr", bus.result_addr, 0);
      chk("midrst_result_data", bus.result_data, 0);
      model_reset();
      check_regs("midrst");
      release_reset();

      // Reset with an XOR to r12 in flight
      bus.dbg_addr = 5'd12;
      send(32'h140C5A80, e0);
      bus.instr_valid = 1'b0;
      obs.delete();
      @(posedge clock);
      #3 reset_n = 1'b0;
      @(posedge clock);
      release_reset();
      idle(5);
      chk("flight_pulses", obs.size(), 0);
      #1;
      chk("flight_r12", bus.dbg_data, 12);
      @(posedge clock);
      #1;

      // Random stream with random stalls and gaps
      obs.delete();
      exp_q.delete();
      ill_cnt   = 0;
      exp_ill   = 0;
      rand_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               logic [31:0]   ins;
               logic [5:0]    op;
               int            r, e;
               bit            wr, il;
               logic [AW-1:0] a;
               logic [DW-1:0] d;
               ins = $urandom;
               r   = $urandom_range(0, 19);
               op  = (r <= 15) ? 6'(r % 8) : 6'($urandom_range(8, 63));
               ins[31:26] = op;
               ins[20:16] = 5'($urandom_range(0, 7));
               if (op != 6'd7) begin
                  ins[15:11] = 5'($urandom_range(0, 7));
                  ins[10:6]  = 5'($urandom_range(0, 7));
               end
               send(ins, e);
               model_exec(ins, wr, il, a, d);
               if (wr) exp_q.push_back('{a, d});
               if (il) exp_ill++;
               if ($urandom_range(0, 4) == 0) begin
                  bus.instr_valid = 1'b0;
                  @(posedge clock);
                  #1;
               end
            end
            bus.instr_valid = 1'b0;
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clock);
               #1 bus.stall = ($urandom_range(0, 3) == 0);
            end
            bus.stall = 1'b0;
         end
      join
      idle(10);
      chk("rand_count", obs.size(), exp_q.size());
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         chk($sformatf("rand_addr%0d", i), obs[i].a, exp_q[i].a);
         chk($sformatf("rand_data%0d", i), obs[i].d, exp_q[i].d);
      end
      chk("rand_illegal", ill_cnt, exp_ill);
      check_regs("rand_final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
